mdu_ctrl: RTL and testbench

Multiply/divide unit controller for the pipelined MIPS core's execute stage, alongside the ALU. It accepts mult/multu/div/divu/mthi/mtlo requests, sequences a fixed-latency busy window, and owns the HI/LO register pair. It exports a stall hint so decode can hold later MDU instructions. It honours exception flush at issue time.

---
 rtl/mdu_pkg.sv | 46 ++++
 rtl/mdu_calc.sv | 69 ++++++
 rtl/mdu_ctrl.sv | 125 ++++++++++++
 tb/tb_mdu_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit controller.
//   - MDU operation encodings carried on mdu_op
//   - default busy-window lengths for multiply and divide
//   - controller state type
//   - small decode helpers used by mdu_ctrl and mdu_calc
// Optional feature macro: MDU_MADD_EN (enables madd/maddu, ops 8 and 9).
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd8;
    localparam logic [3:0] MDU_MADDU = 4'd9;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    // Ops that open a busy window and commit to HI/LO later.
    function automatic logic is_compute(input logic [3:0] op);
        logic r;
        r = (op == MDU_MULT) || (op == MDU_MULTU) ||
            (op == MDU_DIV)  || (op == MDU_DIVU);
`ifdef MDU_MADD_EN
        r = r || (op == MDU_MADD) || (op == MDU_MADDU);
`endif
        return r;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_move(input logic [3:0] op);
        return (op == MDU_MTHI) || (op == MDU_MTLO);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational 64-bit MDU datapath.
// Ports:
//   op          - MDU operation (mdu_pkg encodings)
//   in_a, in_b  - rs / rt operands
//   hi_lo       - current {HI,LO}, used for accumulation and as the
//                 pass-through value for non-result cases
//   result      - {HI,LO} value to commit when the operation completes
//   div_by_zero - divide op with zero divisor; HI/LO must not change
// Optional feature macro: MDU_MADD_EN (madd/maddu accumulate into hi_lo).
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [63:0] hi_lo,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    // Sign-extending to 64 bits first lets a plain unsigned multiply give
    // the exact signed product in the low 64 bits.
    assign prod_s = {{32{in_a[31]}}, in_a} * {{32{in_b[31]}}, in_b};
    assign prod_u = {32'd0, in_a} * {32'd0, in_b};

    assign sa          = in_a;
    assign sb          = in_b;
    assign div_by_zero = is_div(op) && (in_b == 32'd0);

    // Divider outputs are forced to zero for a zero divisor so no X from
    // the divide operator can ever reach the pending registers.
    always_comb begin
        quot_s = '0;
        rem_s  = '0;
        quot_u = '0;
        rem_u  = '0;
        if (in_b != 32'd0) begin
            quot_s = sa / sb;
            rem_s  = sa % sb;
            quot_u = in_a / in_b;
            rem_u  = in_a % in_b;
        end
    end

    always_comb begin
        result = hi_lo;
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV:   if (!div_by_zero) result = {rem_s, quot_s};
            MDU_DIVU:  if (!div_by_zero) result = {rem_u, quot_u};
`ifdef MDU_MADD_EN
            MDU_MADD:  result = hi_lo + prod_s;
            MDU_MADDU: result = hi_lo + prod_u;
`endif
            default:   result = hi_lo;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for the execute stage.
// Sequences a fixed-latency busy window per compute op and owns HI/LO.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   start      - E stage holds a valid MDU instruction
//   mdu_op     - operation (mdu_pkg encodings)
//   inA, inB   - rs / rt operands
//   flush      - kill of the E-stage instruction this cycle
//   busy       - registered: operation in flight
//   md_stall   - combinational stall hint for decode
//   hi_out     - current HI
//   lo_out     - current LO
// Optional feature macro: MDU_MADD_EN (adds madd/maddu).
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    input  logic        flush,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t       state;
    mdu_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             commit;
    logic [63:0]      pend_hl;
    logic             pend_we;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [63:0]      calc_result;
    logic             calc_dz;
    logic             op_compute;
    logic             accept;
    logic             compute_accept;
    logic             move_accept;

    mdu_calc u_calc (
        .op          (mdu_op),
        .in_a        (inA),
        .in_b        (inB),
        .hi_lo       ({hi_q, lo_q}),
        .result      (calc_result),
        .div_by_zero (calc_dz)
    );

    assign op_compute     = is_compute(mdu_op);
    assign busy           = (state == ST_RUN);
    assign accept         = start && !busy && !flush && (op_compute || is_move(mdu_op));
    assign compute_accept = accept && op_compute;
    assign move_accept    = accept && is_move(mdu_op);
    assign md_stall       = busy || (start && op_compute && !flush);
    assign hi_out         = hi_q;
    assign lo_out         = lo_q;

    // Next-state logic: the counter doubles as the RUN length; commit fires
    // on the edge that leaves cnt==1, so results appear the cycle busy drops.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (compute_accept) begin
                    state_next = ST_RUN;
                    cnt_next   = is_div(mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            ST_RUN: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    commit     = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // The result is captured at accept so madd sees HI/LO as of that edge;
    // moves cannot collide with a commit because accept requires !busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend_hl <= '0;
            pend_we <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (compute_accept) begin
                pend_hl <= calc_result;
                pend_we <= !calc_dz;
            end
            if (commit && pend_we) begin
                hi_q <= pend_hl[63:32];
                lo_q <= pend_hl[31:0];
            end
            if (move_accept) begin
                if (mdu_op == MDU_MTHI) hi_q <= inA;
                else                    lo_q <= inA;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed, scoreboard-based bench for mdu_ctrl.
// Expected {HI,LO} values come from a behavioural model and are queued at
// issue, then popped when the busy window closes.
// Optional feature macro: MDU_MADD_EN (selects madd expectations).
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        flush;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_hl = '0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdu_op   (mdu_op),
        .inA      (inA),
        .inB      (inB),
        .flush    (flush),
        .busy     (busy),
        .md_stall (md_stall),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    // Behavioural model of the {HI,LO} result.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint sa, sb;
        int     ia, ib;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ia = int'(a);
        ib = int'(b);
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return {32'd0, a} * {32'd0, b};
            4'd3: return (b == 0) ? hl : {32'(ia % ib), 32'(ia / ib)};
            4'd4: return (b == 0) ? hl : {a % b, a / b};
            4'd8: return hl + 64'(sa * sb);
            4'd9: return hl + {32'd0, a} * {32'd0, b};
            default: return hl;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic s, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic f);
        start  = s;
        mdu_op = op;
        inA    = a;
        inB    = b;
        flush  = f;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a compute op in cycle 0, count busy cycles, then compare HI/LO.
    task automatic run_compute(input string tag, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int n_exp, input logic flush_mid);
        int n;
        logic [63:0] e;
        apply_stimulus(1'b1, op, a, b, 1'b0);
        check_output({tag, " stall"}, {63'd0, md_stall}, 64'd1);
        exp_q.push_back(model(op, a, b, model_hl));
        step();
        apply_stimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            apply_stimulus(1'b0, 4'd0, 32'd0, 32'd0, flush_mid && (n == 2));
            step();
        end
        apply_stimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        check_output({tag, " busy_cycles"}, 64'(n), 64'(n_exp));
        e = exp_q.pop_front();
        model_hl = e;
        check_output({tag, " hilo"}, {hi_out, lo_out}, e);
    endtask

    task automatic move_to(input string tag, input logic [3:0] op, input logic [31:0] a);
        apply_stimulus(1'b1, op, a, 32'd0, 1'b0);
        check_output({tag, " stall"}, {63'd0, md_stall}, 64'd0);
        step();
        apply_stimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        if (op == 4'd5) model_hl[63:32] = a;
        else            model_hl[31:0]  = a;
        check_output({tag, " hilo"}, {hi_out, lo_out}, model_hl);
    endtask

    initial begin : main
        int n;
        logic [63:0] e;
        reset = 1'b1;
        apply_stimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        step();
        step();
        reset = 1'b0;
        check_output("reset busy", {63'd0, busy}, 64'd0);
        check_output("reset stall", {63'd0, md_stall}, 64'd0);
        check_output("reset hilo", {hi_out, lo_out}, 64'd0);

        run_compute("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
        run_compute("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
        run_compute("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
        run_compute("divu", 4'd4, 32'd100, 32'd7, 10, 1'b0);
        move_to("mthi", 4'd5, 32'h1234_5678);
        run_compute("divu0", 4'd4, 32'd7, 32'd0, 10, 1'b0);
        move_to("mtlo", 4'd6, 32'hCAFE_0001);

        // Flushed start must be dropped entirely.
        apply_stimulus(1'b1, 4'd1, 32'd3, 32'd3, 1'b1);
        check_output("flush stall", {63'd0, md_stall}, 64'd0);
        step();
        apply_stimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        check_output("flush busy", {63'd0, busy}, 64'd0);
        check_output("flush hilo", {hi_out, lo_out}, model_hl);

        run_compute("flush_run", 4'd1, 32'hFFFF_FFFD, 32'd5, 5, 1'b1);

        // Second compute held in E while busy; accepted once busy drops.
        apply_stimulus(1'b1, 4'd1, 32'h0001_0000, 32'h0001_0000, 1'b0);
        exp_q.push_back(model(4'd1, 32'h0001_0000, 32'h0001_0000, model_hl));
        step();
        apply_stimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        step();
        step();
        apply_stimulus(1'b1, 4'd4, 32'd1000, 32'd9, 1'b0);
        check_output("b2b stall_busy", {63'd0, md_stall}, 64'd1);
        n = 3;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check_output("b2b free_cycle", 64'(n), 64'd6);
        e = exp_q.pop_front();
        model_hl = e;
        check_output("b2b mult hilo", {hi_out, lo_out}, e);
        exp_q.push_back(model(4'd4, 32'd1000, 32'd9, model_hl));
        step();
        apply_stimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        check_output("b2b divu busy_cycles", 64'(n), 64'd10);
        e = exp_q.pop_front();
        model_hl = e;
        check_output("b2b divu hilo", {hi_out, lo_out}, e);

        // Reset in cycle 4 of a divide kills the pending result.
        apply_stimulus(1'b1, 4'd3, 32'd50, 32'd3, 1'b0);
        step();
        apply_stimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_hl = '0;
        check_output("rst_mid busy", {63'd0, busy}, 64'd0);
        check_output("rst_mid hilo", {hi_out, lo_out}, 64'd0);
        for (int i = 0; i < 12; i++) step();
        check_output("rst_mid no_commit", {hi_out, lo_out}, 64'd0);

        move_to("mthi0", 4'd5, 32'd0);
        move_to("mtlo_ff", 4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_compute("madd", 4'd8, 32'd1, 32'd1, 5, 1'b0);
        run_compute("maddu", 4'd9, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
`else
        apply_stimulus(1'b1, 4'd8, 32'd1, 32'd1, 1'b0);
        check_output("madd_off stall", {63'd0, md_stall}, 64'd0);
        step();
        apply_stimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        check_output("madd_off busy", {63'd0, busy}, 64'd0);
        check_output("madd_off hilo", {hi_out, lo_out}, model_hl);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
